// File: rtl/tick_ctrl.sv
`default_nettype none
// ============================================================================
// tick_ctrl - DIV-cycle tick countdown with pause/resume, stop and divided clock | Rev 1.0
// ============================================================================
module tick_ctrl #(
  parameter int DIV = 100000000,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tick,
  output logic          slow_clk,
  output logic [CW-1:0] remaining,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] c_PRE_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] c_PRE_HALF = PW'(DIV / 2);
  localparam logic [CW-1:0] c_REM_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [CW-1:0] r_rem;
  logic          r_tick;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_rem   <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pre <= '0;
          // A start against an empty count falls through, letting a same-cycle load land.
          if (!stop) begin
            if (!pause && start && (r_rem != '0)) begin
              r_state <= S_RUN;
            end else if (load) begin
              r_rem <= load_val;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_rem   <= '0;
          end else if (pause) begin
            r_state <= S_PAUSE;
          end else if (r_pre == c_PRE_MAX) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            if (r_rem != '0) begin
              r_rem <= r_rem - 1'b1;
            end
            if (r_rem == c_REM_ONE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        S_PAUSE: begin
          // Resume keeps the frozen prescaler so the period is not restarted.
          if (stop) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_rem   <= '0;
          end else if (!pause && start) begin
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_pre   <= '0;
          r_rem   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_pre   <= '0;
          r_rem   <= '0;
        end
      endcase
    end
  end

  assign tick      = r_tick;
  assign done      = r_done;
  assign remaining = r_rem;
  assign state     = r_state;
  assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign slow_clk  = (r_state == S_RUN) && (r_pre < c_PRE_HALF);

endmodule
`default_nettype wire

// File: tb/tb_tick_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tick_ctrl - vector table and hand sequences checked through a cycle-stamped scoreboard | Rev 1.0
// ============================================================================
module tb_tick_ctrl;

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] RN  = 2'd1;
  localparam logic [1:0] PS  = 2'd2;
  localparam logic [1:0] DN  = 2'd3;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] rem;
    logic        tick;
    logic        done;
    logic        slow;
    logic        busy;
  } outs_t;

  typedef struct {
    logic        rst;
    logic        start;
    logic        pause;
    logic        stop;
    logic        load;
    logic [15:0] val;
    int          n;
    outs_t       exp;
  } vec_t;

  typedef struct {
    int    cyc;
    int    id;
    outs_t exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset, start, pause, stop, load;
  logic [15:0] load_val;
  logic        tick, slow_clk, busy, done;
  logic [15:0] remaining;
  logic [1:0]  state;

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  sb_t q[$];

  tick_ctrl #(.DIV(10), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .load(load), .load_val(load_val), .tick(tick), .slow_clk(slow_clk),
    .remaining(remaining), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    sb_t   it;
    outs_t act;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      it  = q.pop_front();
      act = {state, remaining, tick, done, slow_clk, busy};
      checks = checks + 1;
      if (act !== it.exp || it.cyc != cyc) begin
        errors = errors + 1;
        $display("FAIL chk%0d cyc=%0d: got st=%0d rem=%0d tick=%0b done=%0b slow=%0b busy=%0b, want st=%0d rem=%0d tick=%0b done=%0b slow=%0b busy=%0b (due cyc %0d)",
                 it.id, cyc, act.st, act.rem, act.tick, act.done, act.slow, act.busy,
                 it.exp.st, it.exp.rem, it.exp.tick, it.exp.done, it.exp.slow, it.exp.busy, it.cyc);
      end
    end
  end

  function automatic outs_t mo(input logic [1:0] s, input int r, input logic t, input logic d,
                               input logic sl, input logic b);
    outs_t o;
    o.st = s; o.rem = 16'(r); o.tick = t; o.done = d; o.slow = sl; o.busy = b;
    return o;
  endfunction

  function automatic vec_t mkv(input logic rs, input logic st, input logic pa, input logic sp,
                               input logic ld, input int val, input int n, input outs_t e);
    vec_t v;
    v.rst = rs; v.start = st; v.pause = pa; v.stop = sp; v.load = ld;
    v.val = 16'(val); v.n = n; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int id);
    sb_t it;
    reset = v.rst; start = v.start; pause = v.pause; stop = v.stop;
    load = v.load; load_val = v.val;
    it.cyc = cyc + v.n;
    it.id  = id;
    it.exp = v.exp;
    q.push_back(it);
    repeat (v.n) @(posedge clk);
    #1;
  endtask

  vec_t tbl[16];
  int   nid = 100;
  outs_t w_act;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; load = 1'b0; load_val = '0;

    repeat (2) @(posedge clk);
    #1;
    w_act = {state, remaining, tick, done, slow_clk, busy};
    checks = checks + 1;
    if (w_act !== mo(IDL, 0, 0, 0, 0, 0)) begin
      errors = errors + 1;
      $display("FAIL reset-state cyc=%0d: got st=%0d rem=%0d tick=%0b done=%0b slow=%0b busy=%0b",
               cyc, w_act.st, w_act.rem, w_act.tick, w_act.done, w_act.slow, w_act.busy);
    end

    // Basic countdown (start edge = cycle 0), then ignored-command cases.
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 2,  mo(IDL, 0, 0, 0, 0, 0));
    tbl[1]  = mkv(0, 0, 0, 0, 1, 3, 1,  mo(IDL, 3, 0, 0, 0, 0));
    tbl[2]  = mkv(0, 1, 0, 0, 0, 0, 1,  mo(RN,  3, 0, 0, 1, 1));
    tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 4,  mo(RN,  3, 0, 0, 1, 1));
    tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 1,  mo(RN,  3, 0, 0, 0, 1));
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 4,  mo(RN,  3, 0, 0, 0, 1));
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 1,  mo(RN,  2, 1, 0, 1, 1));
    tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 1,  mo(RN,  2, 0, 0, 1, 1));
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 9,  mo(RN,  1, 1, 0, 1, 1));
    tbl[9]  = mkv(0, 0, 0, 0, 0, 0, 10, mo(DN,  0, 1, 1, 0, 0));
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1,  mo(IDL, 0, 0, 0, 0, 0));
    tbl[11] = mkv(0, 1, 0, 0, 0, 0, 1,  mo(IDL, 0, 0, 0, 0, 0));
    tbl[12] = mkv(0, 1, 0, 0, 1, 4, 1,  mo(IDL, 4, 0, 0, 0, 0));
    tbl[13] = mkv(0, 1, 0, 0, 0, 0, 1,  mo(RN,  4, 0, 0, 1, 1));
    tbl[14] = mkv(0, 0, 0, 0, 1, 9, 1,  mo(RN,  4, 0, 0, 1, 1));
    tbl[15] = mkv(0, 0, 1, 1, 0, 0, 1,  mo(IDL, 0, 0, 0, 0, 0));

    for (int i = 0; i < 16; i++) apply(tbl[i], i);

    // Pause at pre=4: frozen 7 cycles, first tick 17 cycles after start.
    apply(mkv(1, 0, 0, 0, 0, 0, 1, mo(IDL, 0, 0, 0, 0, 0)), nid++);
    apply(mkv(0, 0, 0, 0, 1, 2, 1, mo(IDL, 2, 0, 0, 0, 0)), nid++);
    apply(mkv(0, 1, 0, 0, 0, 0, 1, mo(RN,  2, 0, 0, 1, 1)), nid++);
    apply(mkv(0, 0, 0, 0, 0, 0, 4, mo(RN,  2, 0, 0, 1, 1)), nid++);
    for (int i = 0; i < 6; i++)
      apply(mkv(0, 0, 1, 0, 0, 0, 1, mo(PS, 2, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 1, 0, 0, 0, 0, 1, mo(RN,  2, 0, 0, 1, 1)), nid++);
    for (int i = 0; i < 5; i++)
      apply(mkv(0, 0, 0, 0, 0, 0, 1, mo(RN, 2, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 0, 0, 0, 0, 0, 1, mo(RN,  1, 1, 0, 1, 1)), nid++);

    // Pause landing exactly on pre=9 suppresses that tick; resume then ticks to DONE.
    apply(mkv(0, 0, 0, 0, 0, 0, 9, mo(RN,  1, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 0, 1, 0, 0, 0, 1, mo(PS,  1, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 1, 0, 0, 0, 0, 1, mo(RN,  1, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 0, 0, 0, 0, 0, 1, mo(DN,  0, 1, 1, 0, 0)), nid++);
    apply(mkv(0, 0, 0, 0, 0, 0, 1, mo(IDL, 0, 0, 0, 0, 0)), nid++);

    // Stop from PAUSE clears the count.
    apply(mkv(0, 0, 0, 0, 1, 3, 1, mo(IDL, 3, 0, 0, 0, 0)), nid++);
    apply(mkv(0, 1, 0, 0, 0, 0, 1, mo(RN,  3, 0, 0, 1, 1)), nid++);
    apply(mkv(0, 0, 1, 0, 0, 0, 1, mo(PS,  3, 0, 0, 0, 1)), nid++);
    apply(mkv(0, 0, 1, 1, 0, 0, 1, mo(IDL, 0, 0, 0, 0, 0)), nid++);

    // Reset at cycle 23 of a 5-tick run, then silence.
    apply(mkv(0, 0, 0, 0, 1, 5, 1,  mo(IDL, 5, 0, 0, 0, 0)), nid++);
    apply(mkv(0, 1, 0, 0, 0, 0, 1,  mo(RN,  5, 0, 0, 1, 1)), nid++);
    apply(mkv(0, 0, 0, 0, 0, 0, 22, mo(RN,  3, 0, 0, 1, 1)), nid++);
    apply(mkv(1, 0, 0, 0, 0, 0, 1,  mo(IDL, 0, 0, 0, 0, 0)), nid++);
    for (int i = 0; i < 12; i++)
      apply(mkv(0, 0, 0, 0, 0, 0, 1, mo(IDL, 0, 0, 0, 0, 0)), nid++);

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL expired-wait: %0d scheduled check(s) never evaluated", q.size());
    end
    w_act = {state, remaining, tick, done, slow_clk, busy};
    checks = checks + 1;
    if (w_act !== mo(IDL, 0, 0, 0, 0, 0)) begin
      errors = errors + 1;
      $display("FAIL final-idle cyc=%0d: got st=%0d rem=%0d tick=%0b done=%0b slow=%0b busy=%0b",
               cyc, w_act.st, w_act.rem, w_act.tick, w_act.done, w_act.slow, w_act.busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
